r_instr_encoder: RTL

//  Inverse of the R-type translate/control decoder: converts ALU operation requests (aop, rs, rt, rd)

---
 rtl/r_instr_encoder_pkg.sv | 21 ++
 rtl/r_instr_encoder_if.sv | 23 ++
 rtl/r_instr_encoder_sync_fifo.sv | 32 +++
 rtl/r_instr_encoder.sv | 64 ++++++
 4 files changed

// File: rtl/r_instr_encoder_pkg.sv
// r_instr_encoder_pkg: shared R-type opcode/funct constants and drain FSM states
package r_instr_encoder_pkg;
  localparam logic [2:0] AOP_AND  = 3'b000;
  localparam logic [2:0] AOP_OR   = 3'b001;
  localparam logic [2:0] AOP_XOR  = 3'b010;
  localparam logic [2:0] AOP_NOR  = 3'b011;
  localparam logic [2:0] AOP_ADD  = 3'b100;
  localparam logic [2:0] AOP_SUB  = 3'b101;
  localparam logic [2:0] AOP_SLTU = 3'b110;
  localparam logic [2:0] AOP_SLLV = 3'b111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_STALL} drain_t;
endpackage

// File: rtl/r_instr_encoder_if.sv
// r_instr_encoder_if: encode request handshake plus instruction-memory write bus
interface r_instr_encoder_if #(parameter int AW = 6);
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_aop;
  logic [4:0]    req_rs;
  logic [4:0]    req_rt;
  logic [4:0]    req_rd;
  logic          base_load;
  logic [AW-1:0] base_addr;
  logic          imem_busy;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  modport master (
    output req_valid, req_aop, req_rs, req_rt, req_rd, base_load, base_addr, imem_busy,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );
  modport slave (
    input  req_valid, req_aop, req_rs, req_rt, req_rd, base_load, base_addr, imem_busy,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/r_instr_encoder_sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, show-ahead read data
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign dout  = mem[rp[PW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[PW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/r_instr_encoder.sv
// r_instr_encoder: encodes ALU op requests into MIPS R-type words and streams them into imem
module r_instr_encoder
  import r_instr_encoder_pkg::*;
#(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  r_instr_encoder_if.slave      bus,
  output logic [7:0]            wr_count,
  output logic                  idle
);
  logic [5:0]    funct;
  logic [31:0]   word, head;
  logic          push, pop, full, empty;
  logic [AW-1:0] ptr;
  drain_t        state, next;
  always_comb begin
    funct = FN_SLLV;
    case (bus.req_aop)
      AOP_AND:  funct = FN_AND;
      AOP_OR:   funct = FN_OR;
      AOP_XOR:  funct = FN_XOR;
      AOP_NOR:  funct = FN_NOR;
      AOP_ADD:  funct = FN_ADD;
      AOP_SUB:  funct = FN_SUB;
      AOP_SLTU: funct = FN_SLTU;
      AOP_SLLV: funct = FN_SLLV;
    endcase
  end
  assign word = {OP_RTYPE, bus.req_rs, bus.req_rt, bus.req_rd, 5'b00000, funct};
  assign push = bus.req_valid && !full;
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(word), .pop(pop),
    .dout(head), .full(full), .empty(empty)
  );
  // state names what the write port does this cycle: S_WRITE is the imem_we pulse
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= next;
  always_comb next = empty ? S_IDLE : bus.imem_busy ? S_STALL : S_WRITE;
  always_comb begin
    pop           = next == S_WRITE;
    bus.imem_we   = state == S_WRITE;
    bus.req_ready = !full;
    idle          = empty && state != S_WRITE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr            <= '0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      wr_count       <= '0;
    end else if (pop) begin
      ptr            <= ptr + 1'b1;
      bus.imem_addr  <= ptr;
      bus.imem_wdata <= head;
      wr_count       <= (wr_count == 8'hff) ? wr_count : wr_count + 8'd1;
    end else if (empty && bus.base_load) begin
      ptr <= bus.base_addr;
    end
  end
endmodule
